// File: rtl/uart_rx_ctrl_if.sv
//==============================================================================
// Module   : uart_rx_ctrl_if
// Brief    : Configuration, receiver-event and FIFO-read bundle for uart_rx_ctrl.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int FIFO_DEPTH     = 4
);
    localparam int C_CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                      cfg_wr;
    logic [PRESCALE_WIDTH-1:0] cfg_prescale;
    logic                      cfg_par_en;
    logic                      cfg_par_typ;
    logic                      cfg_pending;
    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [DATA_WIDTH-1:0]     rx_p_data;
    logic                      rx_data_valid;
    logic                      rx_par_err;
    logic                      rx_stp_err;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_valid;
    logic                      rd_ready;
    logic [C_CNT_WIDTH-1:0]    fifo_count;
    logic [7:0]                par_err_cnt;
    logic [7:0]                stp_err_cnt;
    logic                      overrun;
    logic                      clr_status;

    modport master (
        output cfg_wr, cfg_prescale, cfg_par_en, cfg_par_typ, RX_IN,
               rx_p_data, rx_data_valid, rx_par_err, rx_stp_err,
               rd_ready, clr_status,
        input  cfg_pending, Prescale, PAR_EN, PAR_TYP, rd_data, rd_valid,
               fifo_count, par_err_cnt, stp_err_cnt, overrun
    );

    modport slave (
        input  cfg_wr, cfg_prescale, cfg_par_en, cfg_par_typ, RX_IN,
               rx_p_data, rx_data_valid, rx_par_err, rx_stp_err,
               rd_ready, clr_status,
        output cfg_pending, Prescale, PAR_EN, PAR_TYP, rd_data, rd_valid,
               fifo_count, par_err_cnt, stp_err_cnt, overrun
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
//==============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART_RX runtime config owner, frame tracker, byte FIFO, error stats.
// Revision : 1.0
//==============================================================================
`default_nettype none

module uart_rx_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int FIFO_DEPTH     = 4,
    parameter int RST_PRESCALE   = 8,
    parameter bit RST_PAR_EN     = 1'b1,
    parameter bit RST_PAR_TYP    = 1'b0
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    uart_rx_ctrl_if.slave      bus
);
    localparam int C_AW = $clog2(FIFO_DEPTH);
    localparam int C_CW = C_AW + 1;
    localparam int C_TW = PRESCALE_WIDTH + 4;
    localparam logic [PRESCALE_WIDTH-1:0] C_RST_PS   = PRESCALE_WIDTH'(RST_PRESCALE);
    localparam logic [C_CW-1:0]           C_FULL_CNT = C_CW'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                    state_q;
    logic [C_TW-1:0]           timer_q;
    logic                      rx_meta_q, rx_s_q, rx_s_prev_q;
    logic                      valid_prev_q, par_prev_q, stp_prev_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q, pend_prescale_q;
    logic                      par_en_q, par_typ_q, pend_par_en_q, pend_par_typ_q;
    logic                      pending_q;
    logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [C_AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [C_CW-1:0]           count_q, count_d;
    logic [7:0]                par_cnt_q, par_cnt_d, stp_cnt_q, stp_cnt_d;
    logic                      overrun_q, overrun_d;

    logic            fall, evt_valid, evt_par, evt_stp, evt_any;
    logic            apply, push_req, push_ok, pop, full;
    logic [C_TW-1:0] wd_limit;

    assign fall      = rx_s_prev_q & ~rx_s_q;
    assign evt_valid = bus.rx_data_valid & ~valid_prev_q;
    assign evt_par   = bus.rx_par_err & ~par_prev_q;
    assign evt_stp   = bus.rx_stp_err & ~stp_prev_q;
    assign evt_any   = evt_valid | evt_par | evt_stp;
    // 12*Prescale as 8x + 4x so no multiplier is inferred
    assign wd_limit  = ({4'b0, prescale_q} << 3) + ({4'b0, prescale_q} << 2);

    // fall requires rx_s==0, so it can never coincide with an apply
    assign apply    = (state_q == S_IDLE) & rx_s_q & pending_q & ~fall;
    assign full     = (count_q == C_FULL_CNT);
    assign pop      = (count_q != '0) & bus.rd_ready;
    assign push_req = evt_valid & ~evt_par & ~evt_stp;
    assign push_ok  = push_req & (~full | pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_s_prev_q  <= 1'b1;
            valid_prev_q <= 1'b0;
            par_prev_q   <= 1'b0;
            stp_prev_q   <= 1'b0;
        end else begin
            rx_meta_q    <= bus.RX_IN;
            rx_s_q       <= rx_meta_q;
            rx_s_prev_q  <= rx_s_q;
            valid_prev_q <= bus.rx_data_valid;
            par_prev_q   <= bus.rx_par_err;
            stp_prev_q   <= bus.rx_stp_err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        state_q <= S_BUSY;
                        timer_q <= '0;
                    end
                end
                S_BUSY: begin
                    if (evt_any || (timer_q == wd_limit)) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A write landing in the apply cycle becomes the next pending value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prescale_q      <= C_RST_PS;
            par_en_q        <= RST_PAR_EN;
            par_typ_q       <= RST_PAR_TYP;
            pend_prescale_q <= '0;
            pend_par_en_q   <= 1'b0;
            pend_par_typ_q  <= 1'b0;
            pending_q       <= 1'b0;
        end else begin
            if (apply) begin
                prescale_q <= pend_prescale_q;
                par_en_q   <= pend_par_en_q;
                par_typ_q  <= pend_par_typ_q;
                pending_q  <= 1'b0;
            end
            if (bus.cfg_wr) begin
                pend_prescale_q <= bus.cfg_prescale;
                pend_par_en_q   <= bus.cfg_par_en;
                pend_par_typ_q  <= bus.cfg_par_typ;
                pending_q       <= 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        par_cnt_d = bus.clr_status ? 8'd0 : par_cnt_q;
        if (evt_par) begin
            par_cnt_d = bus.clr_status ? 8'd1 :
                        ((par_cnt_q == 8'hFF) ? 8'hFF : par_cnt_q + 8'd1);
        end

        stp_cnt_d = bus.clr_status ? 8'd0 : stp_cnt_q;
        if (evt_stp) begin
            stp_cnt_d = bus.clr_status ? 8'd1 :
                        ((stp_cnt_q == 8'hFF) ? 8'hFF : stp_cnt_q + 8'd1);
        end

        overrun_d = bus.clr_status ? 1'b0 : overrun_q;
        if (push_req && full && !pop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            par_cnt_q <= '0;
            stp_cnt_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= bus.rx_p_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q   <= count_d;
            par_cnt_q <= par_cnt_d;
            stp_cnt_q <= stp_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.cfg_pending = pending_q;
    assign bus.Prescale    = prescale_q;
    assign bus.PAR_EN      = par_en_q;
    assign bus.PAR_TYP     = par_typ_q;
    assign bus.rd_data     = mem_q[rd_ptr_q];
    assign bus.rd_valid    = (count_q != '0);
    assign bus.fifo_count  = count_q;
    assign bus.par_err_cnt = par_cnt_q;
    assign bus.stp_err_cnt = stp_cnt_q;
    assign bus.overrun     = overrun_q;

endmodule

`default_nettype wire
